// File: rtl/vga_grid_scanout.sv
// 640x480@60 VGA scan-out of the Tetris grid memory (read port B).
// Counters -> address -> sync read -> colour, with sync delayed to match.
module vga_grid_scanout #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP = 33,
  parameter int GRID_X0 = 240,
  parameter int GRID_Y0 = 80,
  parameter int CELL_SHIFT = 4,
  parameter int GRID_COLS = 10,
  parameter int GRID_ROWS = 20,
  parameter logic [7:0] BG_COLOR = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] addr_b,
  input  logic [7:0]  q_b,
  output logic [7:0]  rgb,
  output logic        hsync,
  output logic        vsync,
  output logic        blank,
  output logic        frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS = 10'(V_VISIBLE);
  localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_LAST = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_LAST = 10'(V_VISIBLE + V_FP + V_SYNC - 1);
  localparam logic [9:0] GX_FIRST = 10'(GRID_X0);
  localparam logic [9:0] GX_END =
    10'(GRID_X0 + (GRID_COLS << CELL_SHIFT));
  localparam logic [9:0] GY_FIRST = 10'(GRID_Y0);
  localparam logic [9:0] GY_END =
    10'(GRID_Y0 + (GRID_ROWS << CELL_SHIFT));
  localparam logic [15:0] COLS16 = 16'(GRID_COLS);

  typedef struct packed {
    logic hs_n;
    logic vs_n;
    logic vis;
    logic in_grid;
    logic sof;
  } ctl_t;

  // Sync pipeline resets to the idle (inactive, blanked) levels
  localparam ctl_t CTL_RST = '{
    hs_n: 1'b1,
    vs_n: 1'b1,
    vis: 1'b0,
    in_grid: 1'b0,
    sof: 1'b0
  };

  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic [9:0]  h_off;
  logic [9:0]  v_off;
  logic [15:0] col;
  logic [15:0] row;
  logic [15:0] addr0;
  ctl_t        c0;
  ctl_t        c1;
  ctl_t        c2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      if (v_cnt == V_LAST)
        v_cnt <= '0;
      else
        v_cnt <= v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  always_comb begin
    c0 = CTL_RST;
    c0.hs_n = !((h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST));
    c0.vs_n = !((v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST));
    c0.vis = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    c0.in_grid = c0.vis
      && (h_cnt >= GX_FIRST) && (h_cnt < GX_END)
      && (v_cnt >= GY_FIRST) && (v_cnt < GY_END);
    c0.sof = (h_cnt == 10'd0) && (v_cnt == V_VIS);
  end

  assign h_off = h_cnt - GX_FIRST;
  assign v_off = v_cnt - GY_FIRST;
  assign col = {6'd0, h_off} >> CELL_SHIFT;
  assign row = {6'd0, v_off} >> CELL_SHIFT;
  // Constant multiply reduces to shift-add
  assign addr0 = row * COLS16 + col;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c1 <= CTL_RST;
      c2 <= CTL_RST;
      addr_b <= '0;
    end else begin
      c1 <= c0;
      c2 <= c1;
      addr_b <= c0.in_grid ? addr0 : 16'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
      blank <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      if (c2.in_grid)
        rgb <= q_b;
      else if (c2.vis)
        rgb <= BG_COLOR;
      else
        rgb <= 8'h00;
      hsync <= c2.hs_n;
      vsync <= c2.vs_n;
      blank <= !c2.vis;
      frame_start <= c2.sof;
    end
  end

endmodule

// File: tb/tb_vga_grid_scanout.sv
// Bench for vga_grid_scanout on a reduced raster with a small
// sync-read memory model and a per-pixel expected-output queue.
module tb_vga_grid_scanout;

  localparam int HV = 64, HF = 4, HS = 8, HB = 4;
  localparam int VV = 96, VF = 2, VS = 2, VB = 3;
  localparam int GX0 = 12, GY0 = 8, CS = 2;
  localparam int GC = 10, GR = 20;
  localparam logic [7:0] BG = 8'h5A;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int GXE = GX0 + (GC << CS);
  localparam int GYE = GY0 + (GR << CS);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] addr_b;
  logic [7:0]  q_b = 8'h00;
  logic [7:0]  rgb;
  logic        hsync, vsync, blank, frame_start;
  logic [7:0]  mem [0:255];

  typedef struct {
    logic [7:0] rgb;
    logic hs, vs, bl, fs;
    int h, v;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          mh, mv;
  logic [15:0] exp_addr;
  bit          corner_mode = 0;

  vga_grid_scanout #(
    .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .GRID_X0(GX0), .GRID_Y0(GY0), .CELL_SHIFT(CS),
    .GRID_COLS(GC), .GRID_ROWS(GR), .BG_COLOR(BG)
  ) dut (
    .clk(clk), .rst_n(rst_n), .addr_b(addr_b), .q_b(q_b),
    .rgb(rgb), .hsync(hsync), .vsync(vsync), .blank(blank),
    .frame_start(frame_start)
  );

  always #20 clk = ~clk;
  always @(posedge clk) q_b <= mem[addr_b[7:0]];

  function automatic bit in_grid(input int h, input int v);
    return h < HV && v < VV && h >= GX0 && h < GXE
      && v >= GY0 && v < GYE;
  endfunction

  function automatic logic [15:0] addr_model(input int h, input int v);
    if (!in_grid(h, v)) return 16'd0;
    return 16'(((v - GY0) >> CS) * GC + ((h - GX0) >> CS));
  endfunction

  function automatic exp_t model(input int h, input int v);
    exp_t e;
    bit vis;
    vis = (h < HV) && (v < VV);
    e.h = h;
    e.v = v;
    if (in_grid(h, v)) e.rgb = mem[addr_model(h, v)];
    else if (vis) e.rgb = BG;
    else e.rgb = 8'h00;
    e.hs = !(h >= HV + HF && h < HV + HF + HS);
    e.vs = !(v >= VV + VF && v < VV + VF + VS);
    e.bl = !vis;
    e.fs = (h == 0) && (v == VV);
    return e;
  endfunction

  task automatic restart_model();
    exp_t r;
    r.rgb = 8'h00; r.hs = 1; r.vs = 1; r.bl = 1; r.fs = 0;
    r.h = -1; r.v = -1;
    sb.delete();
    repeat (3) sb.push_back(r);
    mh = 0;
    mv = 0;
    exp_addr = 16'd0;
  endtask

  task automatic step_check();
    exp_t e, o;
    e = model(mh, mv);
    sb.push_back(e);
    o = sb.pop_front();
    checks++;
    if ({rgb, hsync, vsync, blank, frame_start}
        !== {o.rgb, o.hs, o.vs, o.bl, o.fs}) begin
      errors++;
      $display("FAIL pixel (%0d,%0d): got rgb=%h hs=%b vs=%b bl=%b fs=%b want rgb=%h hs=%b vs=%b bl=%b fs=%b",
        o.h, o.v, rgb, hsync, vsync, blank, frame_start,
        o.rgb, o.hs, o.vs, o.bl, o.fs);
    end
    checks++;
    if (addr_b !== exp_addr) begin
      errors++;
      $display("FAIL addr_b near (%0d,%0d): got %0d want %0d",
        mh, mv, addr_b, exp_addr);
    end
    if (corner_mode && o.h == GX0 && o.v == GY0) begin
      checks++;
      if (rgb !== 8'd200) begin
        errors++;
        $display("FAIL origin rgb: got %0d want 200", rgb);
      end
    end
    if (corner_mode && o.h == GXE - 1 && o.v == GYE - 1) begin
      checks++;
      if (rgb !== 8'd37) begin
        errors++;
        $display("FAIL corner rgb: got %0d want 37", rgb);
      end
    end
    if (corner_mode && o.h == GXE && o.v == GYE - 1) begin
      checks++;
      if (rgb !== BG) begin
        errors++;
        $display("FAIL right-of-grid rgb: got %h want %h", rgb, BG);
      end
    end
    exp_addr = addr_model(mh, mv);
    if (mh == HT - 1) begin
      mh = 0;
      mv = (mv == VT - 1) ? 0 : mv + 1;
    end else begin
      mh++;
    end
  endtask

  task automatic run_cycles(input int n, input bit chk_first_hs);
    int hs_fall = -1, vs_fall = -1, fs_last = -1;
    int first_hs = -1, fs_cnt = 0, fs_want;
    bit phs = 1, pvs = 1;
    for (int k = 0; k < n; k++) begin
      step_check();
      if (phs && !hsync) begin
        if (first_hs < 0) first_hs = k;
        if (hs_fall >= 0) begin
          checks++;
          if (k - hs_fall != HT) begin
            errors++;
            $display("FAIL hsync period: got %0d want %0d",
              k - hs_fall, HT);
          end
        end
        hs_fall = k;
      end
      if (!phs && hsync && hs_fall >= 0) begin
        checks++;
        if (k - hs_fall != HS) begin
          errors++;
          $display("FAIL hsync low: got %0d want %0d", k - hs_fall, HS);
        end
      end
      if (pvs && !vsync) vs_fall = k;
      if (!pvs && vsync && vs_fall >= 0) begin
        checks++;
        if (k - vs_fall != VS * HT) begin
          errors++;
          $display("FAIL vsync low: got %0d want %0d",
            k - vs_fall, VS * HT);
        end
      end
      if (frame_start === 1'b1) begin
        fs_cnt++;
        checks++;
        if (blank !== 1'b1) begin
          errors++;
          $display("FAIL frame_start blank: got %b want 1", blank);
        end
        if (fs_last >= 0) begin
          checks++;
          if (k - fs_last != FT) begin
            errors++;
            $display("FAIL frame period: got %0d want %0d",
              k - fs_last, FT);
          end
        end
        fs_last = k;
      end
      phs = hsync;
      pvs = vsync;
      @(negedge clk);
    end
    fs_want = (n > VV * HT + 3) ? (n - 1 - (VV * HT + 3)) / FT + 1 : 0;
    checks++;
    if (fs_cnt != fs_want) begin
      errors++;
      $display("FAIL frame_start count: got %0d want %0d", fs_cnt, fs_want);
    end
    if (chk_first_hs) begin
      checks++;
      if (first_hs != HV + HF + 3) begin
        errors++;
        $display("FAIL first hsync low: got %0d want %0d",
          first_hs, HV + HF + 3);
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    checks++;
    if ({rgb, hsync, vsync, blank, frame_start, addr_b}
        !== {8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000}) begin
      errors++;
      $display("FAIL %s: got rgb=%h hs=%b vs=%b bl=%b fs=%b addr=%h want 00 1 1 1 0 0000",
        tag, rgb, hsync, vsync, blank, frame_start, addr_b);
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    restart_model();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
  endtask

  task automatic test_origin_corner();
    rst_n = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = (i < 200) ? 8'(i) : 8'hEE;
    mem[0] = 8'd200;
    mem[199] = 8'd37;
    corner_mode = 1;
    release_reset();
    run_cycles(FT + 200, 1'b1);
    corner_mode = 0;
  endtask

  task automatic test_cell_sweep();
    rst_n = 1'b0;
    for (int i = 0; i < 256; i++)
      mem[i] = (i < 200) ? 8'($urandom_range(0, 255)) : 8'hEE;
    repeat (2) @(negedge clk);
    release_reset();
    run_cycles(2 * FT + 50, 1'b1);
  endtask

  task automatic test_mid_reset();
    run_cycles(20 * HT + 30, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_vals("mid-frame reset");
    repeat (5) @(negedge clk);
    check_reset_vals("held reset");
    rst_n = 1'b1;
    restart_model();
    run_cycles(3 * HT, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    test_reset();
    test_origin_corner();
    test_cell_sweep();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
